// File: rtl/rob_pkg.sv
// Shared ROB definitions: sizing macros, type codes and entry metadata.
// Optional feature macro: ROB_MISPREDICT_CNT_EN (adds a mispredict counter
// output to rob).
`ifndef ROB_PKG_DEFINES
`define ROB_PKG_DEFINES
`define ROB_SIZE      16
`define ROB_IDX_WIDTH 4
`define DATA_WIDTH    32
`define ROB_TYPE_REG  2'd0
`define ROB_TYPE_BR   2'd1
`define ROB_TYPE_ST   2'd2
`endif

package rob_pkg;

  localparam int ROB_SIZE_P = `ROB_SIZE;
  localparam int IDX_W_P    = `ROB_IDX_WIDTH;
  localparam int DATA_W     = `DATA_WIDTH;
  localparam int REG_W      = 5;

  typedef enum logic [1:0] {
    ROB_REG = `ROB_TYPE_REG,
    ROB_BR  = `ROB_TYPE_BR,
    ROB_ST  = `ROB_TYPE_ST
  } rob_type_e;

  // Static per-entry information captured at issue time.
  typedef struct packed {
    rob_type_e         typ;
    logic [REG_W-1:0]  rd;
    logic              pred;
    logic [DATA_W-1:0] pc_alt;
  } rob_meta_t;

endpackage

// File: rtl/rob_if.sv
// ROB bus: decoder issue, result broadcasts, commit and rollback signals.
interface rob_if #(
  parameter int IDX_W = rob_pkg::IDX_W_P,
  parameter int DW    = rob_pkg::DATA_W
);
  // issue side
  logic             rob_full;
  logic [IDX_W-1:0] rob_tail_idx;
  logic             de_in_en;
  logic [1:0]       de_type_in;
  logic [4:0]       de_rd_in;
  logic             de_pred_jump_in;
  logic [DW-1:0]    de_pc_alt_in;
  // result broadcasts
  logic             rs_in_en;
  logic [IDX_W-1:0] rs_rob_idx_in;
  logic [DW-1:0]    rs_val_in;
  logic             lsb_in_en;
  logic [IDX_W-1:0] lsb_rob_idx_in;
  logic [DW-1:0]    lsb_val_in;
  // commit / rollback
  logic             commit_reg_en;
  logic [4:0]       commit_rd;
  logic [DW-1:0]    commit_val;
  logic [IDX_W-1:0] commit_rob_idx;
  logic             commit_store_en;
  logic             roll_back;
  logic [DW-1:0]    roll_back_pc;

  modport master (
    input  rob_full, rob_tail_idx,
    output de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_pc_alt_in,
    output rs_in_en, rs_rob_idx_in, rs_val_in,
    output lsb_in_en, lsb_rob_idx_in, lsb_val_in,
    input  commit_reg_en, commit_rd, commit_val, commit_rob_idx,
    input  commit_store_en, roll_back, roll_back_pc
  );

  modport slave (
    output rob_full, rob_tail_idx,
    input  de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_pc_alt_in,
    input  rs_in_en, rs_rob_idx_in, rs_val_in,
    input  lsb_in_en, lsb_rob_idx_in, lsb_val_in,
    output commit_reg_en, commit_rd, commit_val, commit_rob_idx,
    output commit_store_en, roll_back, roll_back_pc
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order issue into a circular buffer, out-of-order result
// capture, in-order single-entry commit with branch misprediction flush.
// Optional macro ROB_MISPREDICT_CNT_EN adds output mispredict_cnt.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_P
) (
  input  logic clk,
  input  logic rst_in,
  input  logic rdy_in,
  rob_if.slave bus
`ifdef ROB_MISPREDICT_CNT_EN
  ,
  output logic [DATA_W-1:0] mispredict_cnt
`endif
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ROB_SIZE);
  // Two slots of slack cover instructions already in the decoder pipe.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ROB_SIZE - 2);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // pointer / occupancy state
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;

  // entry payload (no reset needed: qualified by busy/ready)
  rob_meta_t         meta_q [ROB_SIZE];
  logic [DATA_W-1:0] val_q  [ROB_SIZE];

  // registered outputs
  logic              commit_reg_en_q, commit_reg_en_d;
  logic              commit_store_en_q, commit_store_en_d;
  logic              roll_back_q, roll_back_d;
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_val_q, commit_val_d;
  logic [IDX_W-1:0]  commit_idx_q, commit_idx_d;
  logic [DATA_W-1:0] roll_back_pc_q, roll_back_pc_d;

  rob_meta_t         head_meta;
  logic [DATA_W-1:0] head_val;
  logic              do_commit, mispred, do_issue, rs_hit, lsb_hit;

  assign head_meta = meta_q[head_q];
  assign head_val  = val_q[head_q];

  // Commit decisions use only registered busy/ready, so a result captured on
  // this edge retires on a later one.
  assign do_commit = rdy_in && busy_q[head_q] && ready_q[head_q];
  assign mispred   = do_commit && (head_meta.typ == ROB_BR) &&
                     (head_val[0] != head_meta.pred);
  assign do_issue  = rdy_in && bus.de_in_en && (count_q != CNT_MAX) &&
                     !roll_back_q && !mispred;
  assign rs_hit    = rdy_in && bus.rs_in_en  && busy_q[bus.rs_rob_idx_in];
  assign lsb_hit   = rdy_in && bus.lsb_in_en && busy_q[bus.lsb_rob_idx_in];

  assign bus.rob_full        = (count_q >= CNT_FULL);
  assign bus.rob_tail_idx    = tail_q;
  assign bus.commit_reg_en   = commit_reg_en_q;
  assign bus.commit_store_en = commit_store_en_q;
  assign bus.roll_back       = roll_back_q;
  assign bus.commit_rd       = commit_rd_q;
  assign bus.commit_val      = commit_val_q;
  assign bus.commit_rob_idx  = commit_idx_q;
  assign bus.roll_back_pc    = roll_back_pc_q;

  // Next-state for pointers, occupancy and per-entry status bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    if (mispred) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end else begin
      if (rs_hit)  ready_d[bus.rs_rob_idx_in]  = 1'b1;
      if (lsb_hit) ready_d[bus.lsb_rob_idx_in] = 1'b1;
      if (do_commit) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + IDX_ONE;
      end
      // tail never equals a committing head: that needs an empty or full ROB
      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = (bus.de_type_in == ROB_ST);
        tail_d          = tail_q + IDX_ONE;
      end
      count_d = count_q + CNT_W'(do_issue) - CNT_W'(do_commit);
    end
  end

  // Next-state for commit/rollback outputs; strobes drop whenever no commit.
  always_comb begin
    commit_reg_en_d   = do_commit && (head_meta.typ == ROB_REG);
    commit_store_en_d = do_commit && (head_meta.typ == ROB_ST);
    roll_back_d       = mispred;
    commit_rd_d       = commit_rd_q;
    commit_val_d      = commit_val_q;
    commit_idx_d      = commit_idx_q;
    roll_back_pc_d    = roll_back_pc_q;
    if (commit_reg_en_d) begin
      commit_rd_d  = head_meta.rd;
      commit_val_d = head_val;
    end
    if (commit_reg_en_d || commit_store_en_d) commit_idx_d = head_q;
    if (mispred) roll_back_pc_d = head_meta.pc_alt;
  end

  // Control state and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      busy_q            <= '0;
      ready_q           <= '0;
      commit_reg_en_q   <= 1'b0;
      commit_store_en_q <= 1'b0;
      roll_back_q       <= 1'b0;
      commit_rd_q       <= '0;
      commit_val_q      <= '0;
      commit_idx_q      <= '0;
      roll_back_pc_q    <= '0;
    end else begin
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      busy_q            <= busy_d;
      ready_q           <= ready_d;
      commit_reg_en_q   <= commit_reg_en_d;
      commit_store_en_q <= commit_store_en_d;
      roll_back_q       <= roll_back_d;
      commit_rd_q       <= commit_rd_d;
      commit_val_q      <= commit_val_d;
      commit_idx_q      <= commit_idx_d;
      roll_back_pc_q    <= roll_back_pc_d;
    end
  end

  // Entry payload capture: metadata at issue, values on accepted broadcasts.
  always_ff @(posedge clk) begin
    if (do_issue) begin
      meta_q[tail_q] <= '{typ:    rob_type_e'(bus.de_type_in),
                          rd:     bus.de_rd_in,
                          pred:   bus.de_pred_jump_in,
                          pc_alt: bus.de_pc_alt_in};
    end
    if (rs_hit)  val_q[bus.rs_rob_idx_in]  <= bus.rs_val_in;
    if (lsb_hit) val_q[bus.lsb_rob_idx_in] <= bus.lsb_val_in;
  end

`ifdef ROB_MISPREDICT_CNT_EN
  logic [DATA_W-1:0] mp_cnt_q;

  // Count rollback pulses; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst_in)       mp_cnt_q <= '0;
    else if (mispred) mp_cnt_q <= mp_cnt_q + DATA_W'(1);
  end

  assign mispredict_cnt = mp_cnt_q;
`endif

endmodule

// File: tb/tb_rob.sv
// Randomized scoreboard bench for rob: a program-order queue model predicts
// commit events and rob_full/rob_tail_idx per edge; a monitor checks them.
module tb_rob;

  logic clk = 1'b0;
  logic rst_in, rdy_in;
  always #5 clk = ~clk;

  rob_if bus ();
`ifdef ROB_MISPREDICT_CNT_EN
  logic [31:0] mispredict_cnt;
`endif

  rob #(.ROB_SIZE(16)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.slave)
`ifdef ROB_MISPREDICT_CNT_EN
    , .mispredict_cnt (mispredict_cnt)
`endif
  );

  // reference model: in-flight instructions in program order
  typedef struct {
    int          idx;
    int          typ;
    int          rd;
    bit          pred;
    logic [31:0] pc;
    bit          rdy;
    logic [31:0] val;
  } ent_t;
  typedef struct {
    int          edge_n;
    int          kind;   // 0 reg, 1 store, 2 rollback
    int          rd;
    logic [31:0] val;
    int          idx;
    logic [31:0] pc;
  } ev_t;
  typedef struct {
    int edge_n;
    bit full;
    int tail;
  } st_t;

  ent_t mq[$];
  ev_t  evq[$];
  st_t  stq[$];
  int   m_tail = 0;
  bit   m_rb = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Predict the effect of the coming edge from the inputs now applied.
  task automatic model_edge();
    int   pre;
    bit   flushed;
    ent_t h;
    flushed = 0;
    if (rst_in) begin
      mq.delete(); m_tail = 0; m_rb = 0;
    end else if (!rdy_in) begin
      m_rb = 0;
    end else begin
      pre = mq.size();
      if (pre > 0 && mq[0].rdy) begin
        h = mq.pop_front();
        if (h.typ == 0)
          evq.push_back('{edge_n: cyc + 1, kind: 0, rd: h.rd, val: h.val, idx: h.idx, pc: 0});
        else if (h.typ == 2)
          evq.push_back('{edge_n: cyc + 1, kind: 1, rd: 0, val: 0, idx: h.idx, pc: 0});
        else if (h.val[0] != h.pred) begin
          evq.push_back('{edge_n: cyc + 1, kind: 2, rd: 0, val: 0, idx: 0, pc: h.pc});
          flushed = 1;
        end
      end
      if (flushed) begin
        mq.delete(); m_tail = 0; m_rb = 1;
      end else begin
        foreach (mq[i]) begin
          if (bus.rs_in_en && mq[i].idx == int'(bus.rs_rob_idx_in)) begin
            mq[i].val = bus.rs_val_in; mq[i].rdy = 1;
          end
          if (bus.lsb_in_en && mq[i].idx == int'(bus.lsb_rob_idx_in)) begin
            mq[i].val = bus.lsb_val_in; mq[i].rdy = 1;
          end
        end
        if (bus.de_in_en && pre != 16 && !m_rb) begin
          mq.push_back('{idx: m_tail, typ: int'(bus.de_type_in), rd: int'(bus.de_rd_in),
                         pred: bus.de_pred_jump_in, pc: bus.de_pc_alt_in,
                         rdy: (bus.de_type_in == 2'd2), val: 0});
          m_tail = (m_tail + 1) % 16;
        end
        m_rb = 0;
      end
    end
    stq.push_back('{edge_n: cyc + 1, full: (mq.size() >= 14), tail: m_tail});
  endtask

  // monitor: per-edge status checks and commit-event scoreboard
  st_t ms;
  ev_t me;
  always @(negedge clk) begin
    if (stq.size() > 0 && stq[0].edge_n == cyc) begin
      ms = stq.pop_front();
      check("rob_full", 64'(bus.rob_full), 64'(ms.full));
      check("rob_tail_idx", 64'(bus.rob_tail_idx), 64'(ms.tail));
    end
    if (bus.commit_reg_en === 1'b1 || bus.commit_store_en === 1'b1 || bus.roll_back === 1'b1) begin
      if (evq.size() == 0) begin
        check("unexpected_commit", 64'(1), 64'(0));
      end else begin
        me = evq.pop_front();
        check("commit_edge", 64'(cyc), 64'(me.edge_n));
        check("commit_reg_en", 64'(bus.commit_reg_en), 64'(me.kind == 0));
        check("commit_store_en", 64'(bus.commit_store_en), 64'(me.kind == 1));
        check("roll_back", 64'(bus.roll_back), 64'(me.kind == 2));
        if (me.kind == 0) begin
          check("commit_rd", 64'(bus.commit_rd), 64'(me.rd));
          check("commit_val", 64'(bus.commit_val), 64'(me.val));
        end
        if (me.kind != 2) check("commit_rob_idx", 64'(bus.commit_rob_idx), 64'(me.idx));
        else check("roll_back_pc", 64'(bus.roll_back_pc), 64'(me.pc));
      end
    end else if (evq.size() > 0 && evq[0].edge_n <= cyc) begin
      me = evq.pop_front();
      check("missing_commit", 64'(cyc), 64'(me.edge_n + 1000000));
    end
  end

  task automatic idle();
    rst_in = 0; rdy_in = 1;
    bus.de_in_en = 0; bus.rs_in_en = 0; bus.lsb_in_en = 0;
  endtask

  task automatic issue(input int typ, input int rd, input bit pred, input logic [31:0] pc);
    bus.de_in_en = 1; bus.de_type_in = 2'(typ); bus.de_rd_in = 5'(rd);
    bus.de_pred_jump_in = pred; bus.de_pc_alt_in = pc;
  endtask

  task automatic rs(input int idx, input logic [31:0] v);
    bus.rs_in_en = 1; bus.rs_rob_idx_in = 4'(idx); bus.rs_val_in = v;
  endtask

  task automatic lsb(input int idx, input logic [31:0] v);
    bus.lsb_in_en = 1; bus.lsb_rob_idx_in = 4'(idx); bus.lsb_val_in = v;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst_in = 1; step(); step(); idle();
  endtask

  // position in mq of an unresolved entry whose idx differs from excl, or -1
  function automatic int pick(input int excl);
    int c[$];
    foreach (mq[i]) if (!mq[i].rdy && mq[i].idx != excl) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  // result value; branches mostly resolve as predicted
  function automatic logic [31:0] mk_val(input int p);
    logic [31:0] v;
    v = $urandom;
    if (mq[p].typ == 1) v[0] = ($urandom_range(0, 5) == 0) ? ~mq[p].pred : mq[p].pred;
    return v;
  endfunction

  initial begin
    idle();
    bus.de_type_in = 0; bus.de_rd_in = 0; bus.de_pred_jump_in = 0; bus.de_pc_alt_in = 0;
    bus.rs_rob_idx_in = 0; bus.rs_val_in = 0; bus.lsb_rob_idx_in = 0; bus.lsb_val_in = 0;
    do_reset();
    check("reset_commit_reg_en", 64'(bus.commit_reg_en), 64'(0));
    check("reset_commit_store_en", 64'(bus.commit_store_en), 64'(0));
    check("reset_roll_back", 64'(bus.roll_back), 64'(0));
    check("reset_commit_val", 64'(bus.commit_val), 64'(0));
    check("reset_tail", 64'(bus.rob_tail_idx), 64'(0));
    check("reset_full", 64'(bus.rob_full), 64'(0));

    // single REG issue then result
    issue(0, 5, 0, 0); step(); idle();
    rs(0, 32'h1234); step(); idle();
    step(); step();

    // fill: 14 -> full, 16 accepted, 17th ignored
    do_reset();
    for (int k = 0; k < 17; k++) begin issue(0, k, 0, 0); step(); end
    idle(); step();
    check("fill_full", 64'(bus.rob_full), 64'(1));
    check("fill_tail_wrapped", 64'(bus.rob_tail_idx), 64'(0));

    // mispredicted branch
    do_reset();
    issue(1, 0, 1, 32'h100); step(); idle();
    rs(0, 32'h0); step(); idle();
    step(); step();
    check("rollback_tail", 64'(bus.rob_tail_idx), 64'(0));

    // REG then ST; load result for the REG releases both back to back
    issue(0, 7, 0, 0); step();
    issue(2, 0, 0, 0); step(); idle();
    lsb(0, 32'hCAFE); step(); idle();
    step(); step(); step();

    // stall while head is ready
    issue(0, 9, 0, 0); step(); idle();
    rs(2, 32'h55); step(); idle();
    rdy_in = 0; step(); step(); step();
    idle(); step(); step();

    // wrap: move head to 15, fill across the wrap, retire in program order
    do_reset();
    for (int k = 0; k < 15; k++) begin
      idle(); issue(0, k, 0, 0);
      if (k > 0) rs(k - 1, 32'(k));
      step();
    end
    idle(); rs(14, 32'd14); step(); idle(); step(); step();
    for (int k = 0; k < 17; k++) begin issue(0, k, 0, 0); step(); end
    idle();
    for (int k = 0; k < 16; k++) begin idle(); rs((15 + k) % 16, 32'(100 + k)); step(); end
    idle(); step(); step();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      int p, p2, ridx;
      idle();
      rst_in = (i == 1200);
      rdy_in = ($urandom_range(0, 9) != 0);
      issue($urandom_range(0, 2), $urandom_range(0, 31), 1'($urandom), $urandom);
      bus.de_in_en = ($urandom_range(0, 99) < (((i / 400) % 2 == 1) ? 85 : 45));
      p = ($urandom_range(0, 2) != 0) ? pick(-1) : -1;
      ridx = -1;
      if (p >= 0) begin rs(mq[p].idx, mk_val(p)); ridx = mq[p].idx; end
      else if ($urandom_range(0, 7) == 0) begin rs($urandom_range(0, 15), $urandom); ridx = int'(bus.rs_rob_idx_in); end
      p2 = ($urandom_range(0, 2) != 0) ? pick(ridx) : -1;
      if (p2 >= 0) lsb(mq[p2].idx, mk_val(p2));
      else if ($urandom_range(0, 7) == 0) begin
        lsb($urandom_range(0, 15), $urandom);
        if (int'(bus.lsb_rob_idx_in) == ridx) bus.lsb_in_en = 0;
      end
      step();
    end
    idle();
    repeat (20) step();
    @(negedge clk); #1;
    check("events_drained", 64'(evq.size()), 64'(0));
    check("status_drained", 64'(stq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, entry count (power of two; index width = `ROB_IDX_WIDTH = log2(ROB_SIZE)).
REQ-002 SHALL have port clk  in  1  system clock; single clock domain.
REQ-003 SHALL have port rst_in  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port rdy_in  in  1  global ready; low pauses the block.
REQ-005 SHALL have port rob_full  out  1  issue back-pressure to the decoder.
REQ-006 SHALL have port rob_tail_idx  out  4  ROB index the next issued instruction receives.
REQ-007 SHALL have port de_in_en  in  1  issue strobe from the decoder.
REQ-008 SHALL have port de_type_in  in  2  entry type: REG=0, BR=1, ST=2.
REQ-009 SHALL have port de_rd_in  in  5  destination register (REG type).
REQ-010 SHALL have port de_pred_jump_in  in  1  predicted branch direction (BR type).
REQ-011 SHALL have port de_pc_alt_in  in  32  PC to resume at if the prediction was wrong.
REQ-012 SHALL have port rs_in_en / rs_rob_idx_in / rs_val_in  in  1/4/32  result broadcast from the reservation station.
REQ-013 SHALL have port lsb_in_en / lsb_rob_idx_in / lsb_val_in  in  1/4/32  result broadcast from the load/store buffer.
REQ-014 SHALL have port commit_reg_en / commit_rd / commit_val / commit_rob_idx  out  1/5/32/4  register commit to the regfile.
REQ-015 SHALL have port commit_store_en  out  1  store at the ROB head may write memory; index on commit_rob_idx.
REQ-016 SHALL have port roll_back / roll_back_pc  out  1/32  misprediction flush and redirect PC.

Function
REQ-017 SHALL be a circular buffer: head/tail pointers wrap modulo ROB_SIZE; a count register ranges from 0 to ROB_SIZE.
REQ-018 SHALL drive rob_full combinationally high when count >= ROB_SIZE-2, a margin of two slots for decoder pipeline latency.
REQ-019 On an edge with rdy_in=1 and de_in_en=1, SHALL write the entry at tail (busy=1; ready=1 for ST, otherwise 0) and advance tail by 1.
REQ-020 SHALL ignore de_in_en when count == ROB_SIZE (no state change) and during the roll_back cycle.
REQ-021 On rs_in_en or lsb_in_en targeting a busy entry, SHALL store the value and set ready=1; when both target different entries in one cycle, both SHALL apply; a broadcast to a non-busy entry SHALL be ignored.
REQ-022 SHALL commit at most one entry per edge: the head entry, only if busy and ready as registered; a result written in the same cycle commits no earlier than the next edge.
REQ-023 A committing REG entry SHALL register commit_reg_en=1 for one cycle with commit_rd, commit_val and commit_rob_idx.
REQ-024 A committing ST entry SHALL register commit_store_en=1 for one cycle with commit_rob_idx.
REQ-025 A committing BR entry whose val[0] equals its pred_jump SHALL retire silently.
REQ-026 A committing BR entry whose val[0] differs from its pred_jump SHALL register roll_back=1 for one cycle with roll_back_pc=pc_alt, and at the same edge SHALL clear all busy bits and reset head, tail and count to 0.
REQ-027 SHALL leave count unchanged on a simultaneous issue and commit.
REQ-028 When rdy_in=0, SHALL freeze all entry and pointer state and clear commit_reg_en, commit_store_en and roll_back to 0 at the edge.

Reset
REQ-029 While rst_in=1 at an edge, SHALL zero head, tail, count and every busy/ready bit, and SHALL drive all commit and roll_back outputs and commit data to 0 by the following cycle; rst_in SHALL override rdy_in and any in-flight commit.

Configuration
REQ-030 With macro ROB_MISPREDICT_CNT_EN defined, SHALL add output mispredict_cnt (32 bits, reset 0) that increments once per roll_back pulse and wraps at 2^32; without the macro, the port and counter SHALL be absent.

Structure
REQ-031 The shared parameter header SHALL hold `ROB_IDX_WIDTH, `DATA_WIDTH, `ROB_SIZE and the type codes `ROB_TYPE_REG, `ROB_TYPE_BR and `ROB_TYPE_ST.
REQ-032 SHALL be a single module with no sub-module.

Verification
REQ-033 Issue REG rd=5 at idx0, then rs broadcast idx0 val=0x1234 -> commit_reg_en=1, commit_rd=5, commit_val=0x1234 on the next edge, count back to 0.
REQ-034 Issue 14 entries with no results -> rob_full=1 with count=14; 16th issue sets count=16 and a 17th issue is ignored.
REQ-035 Issue BR with pred=1 and pc_alt=0x100, then broadcast val=0 -> roll_back=1 with roll_back_pc=0x100 for exactly one cycle; rob_tail_idx=0 afterward.
REQ-036 Issue REG A, then ST B; lsb result for A arrives -> commit_reg_en for A, then commit_store_en with commit_rob_idx=B on consecutive cycles.
REQ-037 Drop rdy_in for 3 cycles while the head is ready -> no commit pulse during the stall; commit occurs on the first edge after rdy_in returns high.
REQ-038 Fill to 16 entries with the tail wrapped past idx15, then commit in order -> indices 15,0,1… commit in program order.
